// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, FSM states and request legality check for the load/store unit.
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [2:0] {IDLE, LOAD, LWAIT, STORE, RESP} state_t;
  function automatic logic bad_req(input logic st, input logic [2:0] f3, input logic [1:0] a);
    logic ill, mis;
    ill = st ? (f3 > F3_W) : (f3 == 3'b011 || f3[2:1] == 2'b11);
    mis = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
    return ill || mis;
  endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: extracts the addressed byte/half/word from a RAM word and extends it.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      off_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata_i[{off_i, 3'b000} +: 8];
    h = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o = funct3_i == F3_B  ? {{(XLEN-8){b[7]}}, b} :
             funct3_i == F3_H  ? {{(XLEN-16){h[15]}}, h} :
             funct3_i == F3_W  ? rdata_i :
             funct3_i == F3_BU ? {{(XLEN-8){1'b0}}, b} :
             funct3_i == F3_HU ? {{(XLEN-16){1'b0}}, h} : '0;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding RV32I load/store sequencer driving a word-addressed RAM.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_error,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_rstrb,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wmask
);
  state_t state_q, state_d;
  logic [XLEN-1:0] addr_q, wdata_q, wdata_d, rdata_q, ld_data;
  logic [2:0] f3_q;
  logic err_q, accept, bad;
  logic [3:0] mask;

  lsu_load_align #(.XLEN(XLEN)) u_align (
    .rdata_i (mem_rdata),
    .off_i   (addr_q[1:0]),
    .funct3_i(f3_q),
    .data_o  (ld_data)
  );

  assign accept = req_valid && state_q == IDLE;
  assign bad = bad_req(req_store, req_funct3, req_addr[1:0]);
  assign wdata_d = req_funct3[1:0] == 2'b00 ? {4{req_wdata[7:0]}} :
                   req_funct3[1:0] == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
  assign mask = f3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0] :
                f3_q[1:0] == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = bad ? RESP : req_store ? STORE : LOAD;
      LOAD:    state_d = LWAIT;
      LWAIT:   state_d = RESP;
      STORE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= wdata_d;
        f3_q    <= req_funct3;
        err_q   <= bad;
        rdata_q <= '0;
      end
      if (state_q == LWAIT) rdata_q <= ld_data;
    end
  end

  // Strobes are gated by reset directly so an in-flight access is killed before the edge.
  assign mem_rstrb = state_q == LOAD && !reset;
  assign mem_wmask = (state_q == STORE && !reset) ? mask : 4'b0000;
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_error = rsp_valid && err_q;
  assign rsp_rdata = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench with a byte-array reference memory and a RAM model.
module tb_load_store_unit;
  logic clk = 1'b0, reset = 1'b1;
  logic req_valid, req_ready, req_store, rsp_valid, rsp_error, mem_rstrb;
  logic [2:0] req_funct3;
  logic [31:0] req_addr, req_wdata, rsp_rdata, mem_addr, mem_rdata, mem_wdata;
  logic [3:0] mem_wmask;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .mem_addr(mem_addr), .mem_rstrb(mem_rstrb),
    .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask)
  );

  logic [31:0] ram [0:2047];
  logic pre_en = 1'b0;
  logic [31:0] pre_addr = 0, pre_data = 0;
  always @(posedge clk) begin
    if (pre_en) ram[pre_addr[12:2]] <= pre_data;
    if (mem_rstrb) mem_rdata <= ram[mem_addr[12:2]];
    for (int i = 0; i < 4; i++)
      if (mem_wmask[i]) ram[mem_addr[12:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    int          nrd;
    int          nwr;
    logic [31:0] addr;
  } exp_t;
  exp_t q[$];
  logic [7:0] ref_mem [0:8191];
  int compared = 0, mismatched = 0;
  int rd_cnt = 0, wr_cnt = 0;
  logic [3:0] last_wmask = 0;
  logic [31:0] last_wdata = 0, last_rdata = 0;
  logic last_err = 0;
  bit prev_hold = 0;
  int last_acc = 0, last_lat = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    pre_en = 1'b1; pre_addr = a; pre_data = w;
    @(negedge clk);
    pre_en = 1'b0;
    for (int k = 0; k < 4; k++) ref_mem[int'(a[12:0]) + k] = w[8*k +: 8];
  endtask

  // Reference: a request is a sized access to a flat byte memory.
  task automatic predict(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output exp_t e);
    int sz, ia;
    bit legal;
    logic [31:0] v;
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    ia = int'(a[12:0]);
    e.err = !legal || (ia % sz != 0);
    e.addr = a; e.rdata = 0; e.nrd = 0; e.nwr = 0; e.acc = 0;
    if (e.err) e.lat = 1;
    else if (st) begin
      e.lat = 2; e.nwr = 1;
      for (int k = 0; k < sz; k++) ref_mem[ia + k] = wd[8*k +: 8];
    end else begin
      e.lat = 3; e.nrd = 1;
      v = 0;
      for (int k = 0; k < sz; k++) v = v | (32'(ref_mem[ia + k]) << (8*k));
      if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
      e.rdata = v;
    end
  endtask

  task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit hold);
    exp_t e;
    int n = 0;
    req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      chk("accept_timeout", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b0; prev_hold = 0;
      return;
    end
    predict(st, f3, a, wd, e);
    e.acc = cyc + 1;
    if (prev_hold) chk("accept_gap", e.acc - last_acc, last_lat + 1);
    last_acc = e.acc; last_lat = e.lat; prev_hold = hold;
    q.push_back(e);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (q.size() != 0) begin
      chk("rsp_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        rd_cnt = 0; wr_cnt = 0;
      end else begin
        if (mem_rstrb) begin
          rd_cnt++;
          if (q.size() > 0) chk("rd_addr", mem_addr, q[0].addr);
        end
        if (mem_wmask != 0) begin
          wr_cnt++; last_wmask = mem_wmask; last_wdata = mem_wdata;
          if (q.size() > 0) chk("wr_addr", mem_addr, q[0].addr);
        end
        if (rsp_valid) begin
          if (q.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 want no response (t=%0t)", $time);
          end else begin
            e = q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_error", {31'b0, rsp_error}, {31'b0, e.err});
            chk("latency", cyc + 1 - e.acc, e.lat);
            chk("rstrb_count", rd_cnt, e.nrd);
            chk("wmask_count", wr_cnt, e.nwr);
            last_rdata = rsp_rdata; last_err = rsp_error;
          end
          rd_cnt = 0; wr_cnt = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit st, hold;
    logic [2:0] f3;
    logic [31:0] a, d;
    int n;
    req_valid = 0; req_store = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_error", {31'b0, rsp_error}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wmask", {28'b0, mem_wmask}, 32'd0);
    chk("rst_mem_rstrb", {31'b0, mem_rstrb}, 32'd0);
    reset = 0;
    repeat (5) begin
      @(negedge clk);
      chk("idle_ready", {31'b0, req_ready}, 32'd1);
      chk("idle_wmask", {28'b0, mem_wmask}, 32'd0);
      chk("idle_rstrb", {31'b0, mem_rstrb}, 32'd0);
    end
    preload(32'h100, 32'h1122_3344);
    preload(32'h200, 32'h80F0_7F01);
    preload(32'h300, 32'h0102_0304);
    for (int i = 0; i < 128; i++) preload(32'h400 + 32'(4*i), $urandom);

    issue(1, 3'b000, 32'h102, 32'hAABB_CCDD, 0);
    wait_idle();
    chk("sb_wmask", {28'b0, last_wmask}, 32'h4);
    chk("sb_wdata", last_wdata, 32'hDDDD_DDDD);
    issue(0, 3'b010, 32'h100, 0, 0);
    wait_idle();
    chk("lw_after_sb", last_rdata, 32'h11DD_3344);

    issue(0, 3'b000, 32'h202, 0, 0); wait_idle();
    chk("lb_sign", last_rdata, 32'hFFFF_FFF0);
    issue(0, 3'b100, 32'h202, 0, 0); wait_idle();
    chk("lbu_zero", last_rdata, 32'h0000_00F0);
    issue(0, 3'b001, 32'h202, 0, 0); wait_idle();
    chk("lh_sign", last_rdata, 32'hFFFF_80F0);
    issue(0, 3'b101, 32'h200, 0, 0); wait_idle();
    chk("lhu_zero", last_rdata, 32'h0000_7F01);

    issue(0, 3'b010, 32'h101, 0, 0); wait_idle();
    chk("lw_misal_err", {31'b0, last_err}, 32'd1);
    chk("lw_misal_rdata", last_rdata, 32'd0);
    issue(1, 3'b001, 32'h103, 32'h1234_5678, 0); wait_idle();
    chk("sh_misal_err", {31'b0, last_err}, 32'd1);
    issue(0, 3'b011, 32'h100, 0, 0); wait_idle();
    chk("ld_f3_011_err", {31'b0, last_err}, 32'd1);

    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    req_store = 1; req_funct3 = 3'b010; req_addr = 32'h300; req_wdata = 32'hDEAD_BEEF;
    req_valid = 1;
    @(posedge clk);
    #1 req_valid = 0;
    #1 reset = 1;
    #1;
    chk("abort_wmask", {28'b0, mem_wmask}, 32'd0);
    chk("abort_rstrb", {31'b0, mem_rstrb}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    prev_hold = 0;
    issue(0, 3'b010, 32'h300, 0, 0); wait_idle();
    chk("abort_no_write", last_rdata, 32'h0102_0304);

    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      a = 32'h400 + 32'(4*i);
      issue(1, 3'b010, a, d, 1);
      issue(0, 3'b010, a, 0, i != 7);
    end
    wait_idle();

    for (int i = 0; i < 200; i++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        n = $urandom_range(0, st ? 2 : 4);
        f3 = st ? 3'(n) : (n < 3 ? 3'(n) : 3'(n + 1));
      end
      a = 32'h400 + 32'($urandom_range(0, 511));
      if ($urandom_range(0, 1) != 0) a[1:0] = 2'b00;
      hold = 1'($urandom_range(0, 1));
      issue(st, f3, a, $urandom, hold);
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    req_valid = 0;
    wait_idle();
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
